// File: rtl/pmod_da2_spi.sv
// pmod_da2_spi: SPI driver for a dual 12-bit Pmod DAC fed by the CORDIC generator.
// It latches signed samples, converts them to offset binary and shifts out back-to-back 16-bit frames.
//
// Ports:
//   clock, resetn         system clock and asynchronous active-low reset
//   en                    frames are issued while high (sampled only in IDLE)
//   sample_a, sample_b    signed samples for channel A (sine) and channel B (cosine)
//   cs, sclk              chip select (active low) and SPI clock (idles high)
//   sdata_a, sdata_b      serial data to the two converters, MSB first
//   busy, frame_done      activity flag and one-cycle end-of-frame pulse
//
// Optional feature: define PMOD_DA2_DUAL_EN to build the channel B path.
// When it is undefined, sdata_b is tied low and sample_b is ignored.

module pmod_da2_spi #(
    parameter int width      = 12,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic [width-1:0] sample_a,
    input  logic [width-1:0] sample_b,
    output logic             cs,
    output logic             sclk,
    output logic             sdata_a,
    output logic             sdata_b,
    output logic             busy,
    output logic             frame_done
);

    localparam int FW = width + 4;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(2 * FW);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * FW - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_cnt_n;
    logic [HW-1:0] half_cnt, half_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;

    // The bit on the wire lives in sdata_x; the shift register only holds
    // the bits still to be sent.
    logic [FW-2:0] sh_a, sh_a_n;
    logic [FW-1:0] word_a;
    logic          cs_n, sclk_n, sdata_a_n, busy_n, done_n;

    // Signed to offset binary: invert the sign bit, pad to the frame width.
    function automatic logic [FW-1:0] to_word(input logic [width-1:0] s);
        return {4'b0000, ~s[width-1], s[width-2:0]};
    endfunction

    assign word_a = to_word(sample_a);

`ifdef PMOD_DA2_DUAL_EN
    logic [FW-2:0] sh_b, sh_b_n;
    logic [FW-1:0] word_b;
    logic          sdata_b_n;

    assign word_b = to_word(sample_b);
`else
    logic unused_sample_b;

    assign unused_sample_b = ^sample_b;
    assign sdata_b         = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        div_cnt_n  = div_cnt;
        half_cnt_n = half_cnt;
        gap_cnt_n  = gap_cnt;
        sh_a_n     = sh_a;
        cs_n       = cs;
        sclk_n     = sclk;
        sdata_a_n  = sdata_a;
        busy_n     = busy;
        done_n     = 1'b0;
`ifdef PMOD_DA2_DUAL_EN
        sh_b_n     = sh_b;
        sdata_b_n  = sdata_b;
`endif
        unique case (state)
            IDLE: begin
                if (en) begin
                    sh_a_n     = word_a[FW-2:0];
                    sdata_a_n  = word_a[FW-1];
`ifdef PMOD_DA2_DUAL_EN
                    sh_b_n     = word_b[FW-2:0];
                    sdata_b_n  = word_b[FW-1];
`endif
                    cs_n       = 1'b0;
                    sclk_n     = 1'b1;
                    busy_n     = 1'b1;
                    div_cnt_n  = '0;
                    half_cnt_n = '0;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    // The final wrap closes the frame instead of raising sclk.
                    if (half_cnt == HALF_LAST) begin
                        cs_n      = 1'b1;
                        sclk_n    = 1'b1;
                        sdata_a_n = 1'b0;
`ifdef PMOD_DA2_DUAL_EN
                        sdata_b_n = 1'b0;
`endif
                        done_n    = 1'b1;
                        gap_cnt_n = '0;
                        state_n   = GAP;
                    end else begin
                        half_cnt_n = half_cnt + HW'(1);
                        sclk_n     = ~sclk;
                        // Data moves only on the rising sclk edge, giving a
                        // full half-period of setup and hold around the fall.
                        if (!sclk) begin
                            sdata_a_n = sh_a[FW-2];
                            sh_a_n    = {sh_a[FW-3:0], 1'b0};
`ifdef PMOD_DA2_DUAL_EN
                            sdata_b_n = sh_b[FW-2];
                            sh_b_n    = {sh_b[FW-3:0], 1'b0};
`endif
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + DW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            div_cnt    <= '0;
            half_cnt   <= '0;
            gap_cnt    <= '0;
            sh_a       <= '0;
            cs         <= 1'b1;
            sclk       <= 1'b1;
            sdata_a    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_cnt_n;
            half_cnt   <= half_cnt_n;
            gap_cnt    <= gap_cnt_n;
            sh_a       <= sh_a_n;
            cs         <= cs_n;
            sclk       <= sclk_n;
            sdata_a    <= sdata_a_n;
            busy       <= busy_n;
            frame_done <= done_n;
        end
    end

`ifdef PMOD_DA2_DUAL_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh_b    <= '0;
            sdata_b <= 1'b0;
        end else begin
            sh_b    <= sh_b_n;
            sdata_b <= sdata_b_n;
        end
    end
`endif

endmodule

// File: tb/tb_pmod_da2_spi.sv
// tb_pmod_da2_spi: randomized scoreboard bench for pmod_da2_spi.
// A frame-level model queues expected words and start cycles; a monitor decodes the SPI lines.

module tb_pmod_da2_spi;

    localparam int W      = 12;
    localparam int CD     = 4;
    localparam int GAPC   = 8;
    localparam int FW     = W + 4;
    localparam int LOW    = 2 * FW * CD;
    localparam int NVALS  = 14;

    logic         clock    = 1'b0;
    logic         resetn   = 1'b0;
    logic         en       = 1'b0;
    logic [W-1:0] sample_a = '0;
    logic [W-1:0] sample_b = '0;
    logic         cs, sclk, sdata_a, sdata_b, busy, frame_done;

    pmod_da2_spi #(
        .width     (W),
        .CLK_DIV   (CD),
        .GAP_CYCLES(GAPC)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .en        (en),
        .sample_a  (sample_a),
        .sample_b  (sample_b),
        .cs        (cs),
        .sclk      (sclk),
        .sdata_a   (sdata_a),
        .sdata_b   (sdata_b),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] wa;
        logic [15:0] wb;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    exp_t mon_e;
    int   cyc    = 0;
    int   m_left = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, req);
        end
    endtask

    // Offset binary is the two's-complement value plus half scale.
    function automatic logic [15:0] conv(input logic [W-1:0] s);
        int v;
        v = (int'(s) >= 2048) ? int'(s) - 4096 : int'(s);
        return 16'(v + 2048);
    endfunction

    // Frame-level model: a frame takes LOW+GAPC cycles after the IDLE
    // decision edge, then the block looks at en again.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_left = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (m_left > 0) begin
                m_left--;
            end else if (en) begin
                m_e.wa    = conv(sample_a);
`ifdef PMOD_DA2_DUAL_EN
                m_e.wb    = conv(sample_b);
`else
                m_e.wb    = 16'h0000;
`endif
                m_e.start = cyc;
                exp_q.push_back(m_e);
                m_left    = LOW + GAPC;
            end
        end
    end

    logic        cs_q     = 1'b1;
    logic        sclk_q   = 1'b1;
    bit          in_frame = 1'b0;
    logic [15:0] got_a, got_b;
    int          nfall, nlow;

    always @(negedge clock) begin
        if (!resetn) begin
            in_frame = 1'b0;
            cs_q     = 1'b1;
            sclk_q   = 1'b1;
        end else begin
            chk("busy", busy, m_left > 0);
`ifndef PMOD_DA2_DUAL_EN
            chk("sdata_b_tied", sdata_b, 1'b0);
`endif
            if (frame_done && !(!cs_q && cs)) begin
                chk("frame_done_stray", frame_done, 1'b0);
            end
            if (cs) begin
                chk("idle_sclk", sclk, 1'b1);
                chk("idle_sdata_a", sdata_a, 1'b0);
            end
            if (cs_q && !cs) begin
                in_frame = 1'b1;
                nfall    = 0;
                nlow     = 0;
                got_a    = '0;
                got_b    = '0;
                chk("frame_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("cs_fall_cycle", cyc, exp_q[0].start);
                end
            end
            if (!cs && in_frame) begin
                nlow++;
                if (sclk_q && !sclk) begin
                    got_a = {got_a[14:0], sdata_a};
                    got_b = {got_b[14:0], sdata_b};
                    nfall++;
                end
            end
            if (!cs_q && cs && in_frame) begin
                in_frame = 1'b0;
                chk("frame_done_at_end", frame_done, 1'b1);
                chk("sclk_falls", nfall, FW);
                chk("cs_low_cycles", nlow, LOW);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("word_a", got_a, mon_e.wa);
                    chk("word_b", got_b, mon_e.wb);
                end
            end
            cs_q   = cs;
            sclk_q = sclk;
        end
    end

    task automatic wait_new_frame(input string tag);
        int n = 0;
        while (cs === 1'b0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        while (cs !== 1'b0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_cs_fall"}, cs, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    logic [W-1:0] vals [NVALS];

    initial begin
        vals[0] = 12'h000;
        vals[1] = 12'h7FF;
        vals[2] = 12'h800;
        vals[3] = 12'hFFF;
        vals[4] = 12'h123;
        vals[5] = 12'h456;
        for (int i = 6; i < NVALS; i++) begin
            vals[i] = W'($urandom);
        end

        repeat (3) @(negedge clock);
        chk("rst_cs", cs, 1'b1);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_sdata_a", sdata_a, 1'b0);
        chk("rst_sdata_b", sdata_b, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        #2 resetn = 1'b1;

        @(negedge clock);
        sample_a = vals[0];
        sample_b = 12'h400;
        en       = 1'b1;

        // Each new sample lands mid-frame, so it must only show up in the
        // following frame.
        for (int i = 0; i < NVALS; i++) begin
            wait_new_frame("stream");
            repeat (40) @(negedge clock);
            if (i + 1 < NVALS) begin
                sample_a = vals[i+1];
                sample_b = W'($urandom);
            end
        end

        wait_new_frame("en_drop");
        repeat (9) @(negedge clock);
        en = 1'b0;
        sample_a = W'($urandom);
        wait_idle("en_drop");
        repeat (300) @(negedge clock);
        chk("en_drop_cs_high", cs, 1'b1);

        en = 1'b1;
        wait_new_frame("pre_reset");
        repeat (59) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_cs", cs, 1'b1);
        chk("async_rst_sclk", sclk, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_sdata_a", sdata_a, 1'b0);
        @(negedge clock);
        sample_a = W'($urandom);
        sample_b = W'($urandom);
        #2 resetn = 1'b1;

        wait_new_frame("post_reset");
        repeat (40) @(negedge clock);
        sample_a = W'($urandom);
        sample_b = W'($urandom);
        wait_new_frame("tail");
        repeat (5) @(negedge clock);
        en = 1'b0;
        wait_idle("tail");
        repeat (20) @(negedge clock);
        chk("pending_frames", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmod_da2_spi.md
# pmod_da2_spi

Serial DAC driver that sits directly downstream of the 12-bit CORDIC sine/cosine generator, as the alternative output path to the PWM stage. Each frame it latches the signed 12-bit CORDIC samples and converts them to offset binary. It then shifts them out as 16-bit SPI frames to a dual 12-bit Pmod DAC (two converters sharing CS and SCLK). Frames run back-to-back while enabled, giving a fixed, parameter-defined update rate.

## Interface
- `width`, 12, sample width; the frame is `width + 4` = 16 bits
- `CLK_DIV`, 4, system clock cycles per SCLK half-period (≥1)
- `GAP_CYCLES`, 8, cycles CS stays high between frames (≥1)

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `en`  in  1  level; frames are issued while high
- `sample_a`  in  `width`  signed sample for channel A (sine)
- `sample_b`  in  `width`  signed sample for channel B (cosine)
- `cs`  out  1  DAC chip select, active low
- `sclk`  out  1  SPI clock, idles high
- `sdata_a`  out  1  serial data to DAC A, MSB first
- `sdata_b`  out  1  serial data to DAC B, MSB first
- `busy`  out  1  high whenever state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse at the end of each frame

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE with `en`=1 at a rising edge causes all of the following on that edge:
  - latch the shift word `{4'b0000, ~s[width-1], s[width-2:0]}` per channel (signed to offset binary);
  - `cs`<=0, `sclk`<=1;
  - `sdata_x`<=word bit 15;
  - go to SHIFT.
- SHIFT covers 16 bit periods of 2·`CLK_DIV` cycles each.
  - Divider counter runs 0..`CLK_DIV`-1; every wrap toggles `sclk`.
  - `sclk` is high for the first half of each bit period and low for the second half.
  - The falling edge of `sclk` at mid-bit is the DAC sampling point.
  - On each low→high toggle the shift register shifts left and `sdata_x` takes the next bit.
- End of SHIFT (after 32·`CLK_DIV` cycles), on one edge:
  - `cs`<=1, `sclk`<=1, `sdata_x`<=0;
  - `frame_done`<=1 for one cycle;
  - go to GAP.
- GAP holds for `GAP_CYCLES` cycles, then goes to IDLE.
- `en` and the sample inputs are sampled only in IDLE.
  - Dropping `en` mid-frame does not abort the frame; the current frame and its GAP complete.
  - Sample changes during SHIFT or GAP have no effect on the frame in flight.
- Outputs are registered; no combinational path from input to output.

## Timing
- Reset values while `resetn`=0, asynchronously:
  - `cs`=1, `sclk`=1;
  - `sdata_a`=`sdata_b`=0;
  - `busy`=0, `frame_done`=0;
  - state IDLE; counters and shift registers 0.
- Reset asserted mid-frame: `cs` rises immediately (asynchronously) and the frame is abandoned. After release the block restarts from IDLE.
- First `cs` fall is on the first rising edge after reset release with `en`=1.
- Frame period with `en` held high: 32·`CLK_DIV` + `GAP_CYCLES` + 1 cycles, which is 137 at the defaults. The extra cycle is the IDLE decision cycle.
- `cs` low time is exactly 32·`CLK_DIV` cycles.
- Data setup to the `sclk` falling edge is `CLK_DIV` cycles; hold after it is `CLK_DIV` cycles.
- `frame_done` is high in the first GAP cycle.
- `busy` rises with `cs` and falls on the edge that enters IDLE.

## Configuration
- `PMOD_DA2_DUAL_EN` defined:
  - channel B path is built;
  - `sdata_b` carries `sample_b` in lockstep with channel A.
- `PMOD_DA2_DUAL_EN` undefined:
  - channel B latch and shift register are omitted;
  - `sdata_b` is tied to 0;
  - `sample_b` is ignored;
  - channel A behaviour and timing are unchanged.

## Test plan
- Code conversion: `sample_a` = 0x000, 0x7FF, 0x800, 0xFFF -> shifted words captured on `sclk` falling edges are 0x0800, 0x0FFF, 0x0000, 0x07FF respectively.
- Cadence at defaults with `en` held high: `cs` low for 128 cycles, `cs` falls every 137 cycles, 16 `sclk` falling edges per frame, `frame_done` pulses once per frame, one cycle wide.
- `sample_a` changed from 0x123 to 0x456 at cycle 40 of a frame -> that frame still shifts 0x0923; the next frame shifts 0x0C56.
- `en` dropped at cycle 10 of SHIFT -> frame completes, `frame_done` pulses, `busy` falls after GAP, no further `cs` fall.
- `resetn` pulsed low at cycle 60 of a frame -> `cs`=1, `sclk`=1, `busy`=0 immediately; with `en`=1, the next `cs` fall is on the first edge after release.
- Dual channel: with the macro defined, `sample_b`=0x400 -> `sdata_b` word 0x0C00, aligned bit-for-bit with `sdata_a`. Without the macro, `sdata_b` stays 0 throughout.
